// File: rtl/sipo_framed.sv
// Parametrised serial-in/parallel-out deserializer with word framing and
// optional comma-based alignment (HUNT/LOCKED) for 8b/10b-style links.
module sipo_framed #(
  parameter int unsigned       WIDTH     = 10,
  parameter int unsigned       LSB_FIRST = 0,
  parameter int unsigned       ALIGN_EN  = 1,
  parameter logic [WIDTH-1:0]  COMMA     = 10'b0011111010
) (
  input  logic             clk,
  input  logic             reinicio,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             resync,
  output logic [WIDTH-1:0] parallel_out,
  output logic             parallel_valid,
  output logic             comma_det,
  output logic             locked
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [0:0] ST_RESET  = (ALIGN_EN != 0) ? ST_HUNT : ST_LOCKED;

  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_comma;

  logic [WIDTH-1:0] w_win;
  logic             w_match;
  logic             w_resync;
  logic             w_last;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_win = {serial_in, r_sh[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_win = {r_sh[WIDTH-2:0], serial_in};
    end
  endgenerate

  assign w_match  = (w_win == COMMA) || (w_win == ~COMMA);
  assign w_resync = resync && (ALIGN_EN != 0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reinicio) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_state <= ST_RESET;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_comma <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_comma <= 1'b0;
      if (w_resync) begin
        // Bit still enters the window so the hunt resumes with no gap.
        r_state <= ST_HUNT;
        r_cnt   <= '0;
        if (serial_valid) begin
          r_sh <= w_win;
        end
      end else if (serial_valid) begin
        r_sh <= w_win;
        if (r_state == ST_HUNT) begin
          if (w_match) begin
            r_out   <= w_win;
            r_valid <= 1'b1;
            r_comma <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_LOCKED;
          end
        end else if (w_last) begin
          r_out   <= w_win;
          r_valid <= 1'b1;
          r_comma <= w_match;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign parallel_out   = r_out;
  assign parallel_valid = r_valid;
  assign comma_det      = r_comma;
  assign locked         = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_sipo_framed.sv
// Bench for sipo_framed: an aligning MSB-first instance and a free-running
// LSB-first instance share stimulus and are checked against a bit-history model.
module tb_sipo_framed;

  localparam int unsigned     W = 10;
  localparam logic [W-1:0]    C = 10'b0011111010;

  logic         clk = 1'b0;
  logic         reinicio = 1'b1;
  logic         serial_in = 1'b0;
  logic         serial_valid = 1'b0;
  logic         resync = 1'b0;
  logic [W-1:0] out_a, out_b;
  logic         pv_a, pv_b, cd_a, cd_b, lk_a, lk_b;

  always #5 clk = ~clk;

  sipo_framed #(.WIDTH(W), .LSB_FIRST(0), .ALIGN_EN(1), .COMMA(C)) u_a (
    .clk(clk), .reinicio(reinicio), .serial_in(serial_in),
    .serial_valid(serial_valid), .resync(resync), .parallel_out(out_a),
    .parallel_valid(pv_a), .comma_det(cd_a), .locked(lk_a)
  );

  sipo_framed #(.WIDTH(W), .LSB_FIRST(1), .ALIGN_EN(0), .COMMA(C)) u_b (
    .clk(clk), .reinicio(reinicio), .serial_in(serial_in),
    .serial_valid(serial_valid), .resync(resync), .parallel_out(out_b),
    .parallel_valid(pv_b), .comma_det(cd_b), .locked(lk_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: history of received bits, words assembled from the
  // last W bits; alignment state plus bits counted since the last boundary.
  bit           hist[$];
  bit           m_lock_a;
  int           m_n_a, m_n_b;
  logic [W-1:0] e_out_a, e_out_b;
  bit           e_pv_a, e_cd_a, e_pv_b, e_cd_b;
  int           m_strobes, d_strobes;

  function automatic logic [W-1:0] window(input bit lsb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (lsb_first) w[W-1-i] = hist[hist.size()-1-i];
      else           w[i]     = hist[hist.size()-1-i];
    end
    return w;
  endfunction

  function automatic bit is_comma(input logic [W-1:0] w);
    return (w == C) || (w == ~C);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(W); i++) hist.push_back(1'b0);
    m_lock_a = 1'b0;
    m_n_a = 0;
    m_n_b = 0;
    e_out_a = '0;
    e_out_b = '0;
  endtask

  task automatic model_edge(input bit rst, input bit rs, input bit sv, input bit si);
    logic [W-1:0] wa;
    e_pv_a = 0; e_cd_a = 0; e_pv_b = 0; e_cd_b = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (sv) begin
      hist.push_back(si);
      if (hist.size() > W) void'(hist.pop_front());
    end
    if (rs) begin
      m_lock_a = 1'b0;
      m_n_a = 0;
    end else if (sv) begin
      wa = window(1'b0);
      if (!m_lock_a) begin
        if (is_comma(wa)) begin
          e_out_a = wa; e_pv_a = 1; e_cd_a = 1;
          m_lock_a = 1'b1; m_n_a = 0;
        end
      end else begin
        m_n_a++;
        if (m_n_a == int'(W)) begin
          e_out_a = wa; e_pv_a = 1; e_cd_a = is_comma(wa);
          m_n_a = 0;
        end
      end
    end
    if (sv) begin
      m_n_b++;
      if (m_n_b == int'(W)) begin
        e_out_b = window(1'b1); e_pv_b = 1; e_cd_b = is_comma(e_out_b);
        m_n_b = 0;
      end
    end
    if (e_pv_a) m_strobes++;
  endtask

  task automatic step(input bit rst, input bit rs, input bit sv, input bit si);
    reinicio = rst; resync = rs; serial_valid = sv; serial_in = si;
    @(posedge clk);
    #1;
    model_edge(rst, rs, sv, si);
    if (pv_a === 1'b1) d_strobes++;
    check("a_valid",  {31'd0, pv_a}, {31'd0, e_pv_a});
    check("a_out",    {22'd0, out_a}, {22'd0, e_out_a});
    check("a_comma",  {31'd0, cd_a}, {31'd0, e_cd_a});
    check("a_locked", {31'd0, lk_a}, {31'd0, m_lock_a});
    check("b_valid",  {31'd0, pv_b}, {31'd0, e_pv_b});
    check("b_out",    {22'd0, out_b}, {22'd0, e_out_b});
    check("b_comma",  {31'd0, cd_b}, {31'd0, e_cd_b});
    check("b_locked", {31'd0, lk_b}, 32'd1);
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, bits[i]);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    m_strobes = 0;
    d_strobes = 0;

    // Comma preceded by 3 bits, then a data word.
    do_reset();
    check("rst_out", {22'd0, out_a}, 32'd0);
    check("rst_lock", {31'd0, lk_a}, 32'd0);
    send(32'b101, 3);
    send({22'd0, C}, 10);
    check("s1_pv", {31'd0, pv_a}, 32'd1);
    check("s1_word", {22'd0, out_a}, {22'd0, C});
    check("s1_cd", {31'd0, cd_a}, 32'd1);
    check("s1_lock", {31'd0, lk_a}, 32'd1);
    send(32'b1011011101, 10);
    check("s1_data", {22'd0, out_a}, 32'b1011011101);
    check("s1_data_cd", {31'd0, cd_a}, 32'd0);

    // Inverted comma, then a word with a 5-cycle stall.
    do_reset();
    send(32'b1100000101, 10);
    check("s2_word", {22'd0, out_a}, 32'b1100000101);
    check("s2_cd", {31'd0, cd_a}, 32'd1);
    send(32'b101, 3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
    send(32'b1011101, 7);
    check("s2_pv", {31'd0, pv_a}, 32'd1);
    check("s2_data", {22'd0, out_a}, 32'b1011011101);

    // Free-running LSB-first instance.
    do_reset();
    check("s3_lock", {31'd0, lk_b}, 32'd1);
    send(32'b1000000001, 10);
    check("s3_pv", {31'd0, pv_b}, 32'd1);
    check("s3_w1", {22'd0, out_b}, 32'b1000000001);
    send(32'b1100000000, 10);
    check("s3_w2", {22'd0, out_b}, 32'b0000000011);

    // Reset mid-word, then relock.
    do_reset();
    send(32'b101, 3);
    send({22'd0, C}, 10);
    send(32'b1011, 4);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("s4_out", {22'd0, out_a}, 32'd0);
    check("s4_pv", {31'd0, pv_a}, 32'd0);
    check("s4_lock", {31'd0, lk_a}, 32'd0);
    send({22'd0, C}, 10);
    check("s4_relock", {22'd0, out_a}, {22'd0, C});
    check("s4_lock2", {31'd0, lk_a}, 32'd1);

    // Resync, then comma at a 3-bit offset.
    send(32'b1011011101, 10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("s5_unlock", {31'd0, lk_a}, 32'd0);
    send(32'b110, 3);
    send({22'd0, C}, 10);
    check("s5_word", {22'd0, out_a}, {22'd0, C});
    check("s5_cd", {31'd0, cd_a}, 32'd1);
    check("s5_lock", {31'd0, lk_a}, 32'd1);

    // Random stalls over at least 50 words.
    m_strobes = 0;
    d_strobes = 0;
    for (int i = 0; i < 4000 && m_strobes < 50; i++) begin
      step(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    check("s6_words", {31'd0, (m_strobes >= 50)}, 32'd1);
    check("s6_strobes", d_strobes, m_strobes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_framed.md
Name: sipo_framed

Overview:
- Parametrised serial-in/parallel-out deserializer; successor to the fixed 10-bit `sipo`.
- Adds: configurable width and bit order, a serial-enable qualifier, word framing with a one-cycle `parallel_valid` strobe, and optional comma-based word alignment (HUNT/LOCKED) for 8b/10b-style links.
- Sits between the serial line receiver and the word-level decoder.

Parameters:
- WIDTH, 10: deserialized word width in bits; legal range 2 to 32.
- LSB_FIRST, 0: bit order. 0 means the first received bit lands in `parallel_out[WIDTH-1]`. 1 means it lands in `parallel_out[0]`.
- ALIGN_EN, 1: comma alignment. 1 enables the HUNT/LOCKED alignment machine. 0 means free-running framing from reset.
- COMMA, 10'b0011111010: alignment pattern, WIDTH bits. Its bitwise inverse also matches.

Ports:
- clk  input  1  rising-edge clock.
- reinicio  input  1  reset; synchronous, active-high.
- serial_in  input  1  serial data bit.
- serial_valid  input  1  `serial_in` is sampled only on edges where this is 1.
- resync  input  1  force re-alignment (return to HUNT); ignored when ALIGN_EN=0.
- parallel_out  output  WIDTH  last completed word; registered.
- parallel_valid  output  1  one-cycle strobe: `parallel_out` updated this cycle.
- comma_det  output  1  the word presented with the current strobe matched COMMA or ~COMMA.
- locked  output  1  aligner is in LOCKED.

Behaviour:
- Reset (`reinicio`=1 at an edge) clears:
  - shift register and `bit_cnt` = 0
  - `parallel_out` = 0, `parallel_valid` = 0, `comma_det` = 0
  - state = HUNT if ALIGN_EN=1, else LOCKED; `locked` follows the state.
  - Reset has priority over all other inputs and aborts any partial word.
- Shift window: `win_next` is the shift register after the current bit is shifted in.
  - LSB_FIRST=0: `{sh[WIDTH-2:0], serial_in}`.
  - LSB_FIRST=1: `{serial_in, sh[WIDTH-1:1]}`.
- Edge with `serial_valid`=0: `sh`, `bit_cnt` and state hold; `parallel_out` holds; `parallel_valid`=0; `comma_det`=0.
- `bit_cnt`: width clog2(WIDTH); counts 0 to WIDTH-1, then wraps to 0.
- `parallel_valid` and `comma_det` are 0 on every edge that does not emit a word.
- HUNT (`locked`=0), on each edge with `serial_valid`=1:
  - `sh` <= `win_next`.
  - If `win_next` == COMMA or ~COMMA: `parallel_out` <= `win_next`, `parallel_valid` <= 1, `comma_det` <= 1, `bit_cnt` <= 0, state -> LOCKED.
  - Otherwise no output.
  - The match check applies from the first bit after reset; a stale shift-register prefix is accepted.
- LOCKED (`locked`=1), on each edge with `serial_valid`=1:
  - `sh` <= `win_next`.
  - If `bit_cnt` == WIDTH-1: `parallel_out` <= `win_next`, `parallel_valid` <= 1, `comma_det` <= (`win_next` matches), `bit_cnt` <= 0.
  - Otherwise `bit_cnt` increments.
  - No automatic loss of lock; a comma arriving off-boundary is ignored.
- Latency: `parallel_out` and `parallel_valid` are visible right after the edge that sampled the word's last bit (0 extra cycles).
- `resync`=1 with ALIGN_EN=1 (and `reinicio`=0):
  - state -> HUNT, `bit_cnt` <= 0, `parallel_valid` <= 0.
  - If `serial_valid`=1 the bit is still shifted into `sh`, but no compare is made that cycle.
- ALIGN_EN=0: HUNT is unreachable; `locked` is constant 1; the first word completes on the WIDTH-th valid bit after reset; `comma_det` still reports matches on emitted words.
- Back-to-back words: strobes are spaced exactly WIDTH valid bits apart; with continuous `serial_valid`, `parallel_valid` is high 1 cycle in WIDTH.

Test Plan:
1. Defaults, continuous valid, after reset: send bits 1,0,1, then 0,0,1,1,1,1,1,0,1,0 -> strobe on the 13th bit edge; `parallel_out`=0011111010, `comma_det`=1, `locked`=1. Then send 1,0,1,1,0,1,1,1,0,1 -> strobe on the 10th bit; `parallel_out`=1011011101, `comma_det`=0.
2. Negative comma: send 1,1,0,0,0,0,0,1,0,1 -> lock; `parallel_out`=1100000101, `comma_det`=1. Then hold `serial_valid`=0 for 5 cycles inside the next word -> no strobe; word completes after exactly 10 valid bits.
3. ALIGN_EN=0, LSB_FIRST=1: send 1,0,0,0,0,0,0,0,0,1 -> after reset, `locked`=1; strobe on the 10th bit with `parallel_out`=1000000001. Then send 1,1,0,0,0,0,0,0,0,0 -> `parallel_out`=0000000011.
4. Reset mid-word: lock (scenario 1), send 4 bits, pulse `reinicio` -> all outputs 0, `locked`=0; a following comma re-locks with the correct word.
5. Resync: while locked, pulse `resync` -> `locked`=0 next cycle and no strobes from off-boundary data; a subsequent comma at a 3-bit offset locks with `parallel_out`=0011111010.
6. Stall robustness: random `serial_valid` gaps over 50 words vs. a reference model -> each word value and the strobe count match exactly; `parallel_valid` is never high on an edge with `serial_valid`=0.
